sum_mean: RTL and testbench

Result stage directly downstream of the serial accumulator. It captures the accumulator's signed 16-bit batch sum and the batch length when the accumulator signals completion. It computes the truncated mean (sum / n) and remainder with a bit-serial restoring divider, then presents the result on a valid/ready output handshake. It also flags divide-by-zero and overrun of events that arrive while it is busy.

---
 rtl/sum_mean.sv | 134 +++++++++++++
 tb/tb_sum_mean.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sum_mean.sv
// Result stage after the serial accumulator: captures a batch sum and length on done_i rising,
// divides with a 16-step restoring divider, and presents mean/remainder on a valid/ready handshake.
module sum_mean (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        done_i,
  input  logic [15:0] sum_i,
  input  logic [7:0]  n_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [15:0] mean_o,
  output logic [8:0]  rem_o,
  output logic        div_zero_o,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {StIdle, StDiv, StSign, StValid} state_e;

  state_e      state_q, state_d;
  logic        done_q;
  logic        event_w;
  logic [15:0] dvd_q, dvd_d;      // dividend magnitude, shifts out as quotient shifts in
  logic [8:0]  prem_q, prem_d;
  logic [7:0]  dvs_q, dvs_d;
  logic        sign_q, sign_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mean_q, mean_d;
  logic [8:0]  rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        ov_q, ov_d;
  logic [8:0]  shifted_w;
  logic [8:0]  diff_w;
  logic        ge_w;

  assign event_w   = done_i & ~done_q;
  assign shifted_w = {prem_q[7:0], dvd_q[15]};
  assign ge_w      = shifted_w >= {1'b0, dvs_q};
  assign diff_w    = shifted_w - {1'b0, dvs_q};

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      done_q  <= 1'b1;
      dvd_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      mean_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_i;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      mean_q  <= mean_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (event_w) state_d = (n_i == 8'd0) ? StValid : StDiv;
      StDiv:   if (cnt_q == 4'd15) state_d = StSign;
      StSign:  state_d = StValid;
      StValid: if (ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    mean_d = mean_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    ov_d   = ov_q | (event_w & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (event_w) begin
          if (n_i != 8'd0) begin
            // Magnitude of -32768 wraps to 0x8000, which is the correct unsigned value
            dvd_d  = sum_i[15] ? (~sum_i + 16'd1) : sum_i;
            sign_d = sum_i[15];
            dvs_d  = n_i;
            prem_d = '0;
            cnt_d  = '0;
          end else begin
            mean_d = '0;
            rem_d  = '0;
            dz_d   = 1'b1;
          end
        end
      end
      StDiv: begin
        prem_d = ge_w ? diff_w : shifted_w;
        dvd_d  = {dvd_q[14:0], ge_w};
        cnt_d  = cnt_q + 4'd1;
      end
      StSign: begin
        mean_d = sign_q ? (~dvd_q + 16'd1) : dvd_q;
        rem_d  = sign_q ? (~prem_q + 9'd1) : prem_q;
        dz_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    valid_o    = (state_q == StValid);
    busy_o     = (state_q == StDiv) || (state_q == StSign);
    mean_o     = mean_q;
    rem_o      = rem_q;
    div_zero_o = dz_q;
    overrun_o  = ov_q;
  end

endmodule

// File: tb/tb_sum_mean.sv
// Randomized self-checking bench for sum_mean against an integer-division reference model.
module tb_sum_mean;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        done_i;
  logic [15:0] sum_i;
  logic [7:0]  n_i;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] mean_o;
  logic [8:0]  rem_o;
  logic        div_zero_o;
  logic        busy_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;
  logic ov_exp = 1'b0;

  always #5 clk_i = ~clk_i;

  sum_mean u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .done_i     (done_i),
    .sum_i      (sum_i),
    .n_i        (n_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .mean_o     (mean_o),
    .rem_o      (rem_o),
    .div_zero_o (div_zero_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One batch: keep holds done_i high through the result, mid fires a second event during DIV
  task automatic run_batch(input logic [15:0] s, input logic [7:0] n, input int hold,
                           input bit keep, input bit mid);
    int          sv, nv, em, er, edges;
    logic [15:0] em16;
    logic [8:0]  er9;
    sv = int'($signed(s));
    nv = int'(n);
    if (nv == 0) begin
      em = 0;
      er = 0;
    end else begin
      em = sv / nv;
      er = sv % nv;
    end
    em16 = em[15:0];
    er9  = er[8:0];

    @(negedge clk_i);
    done_i  = 1'b1;
    sum_i   = s;
    n_i     = n;
    ready_i = (hold == 0);
    edges   = 0;
    do begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
      if (edges == 1 && nv != 0) check_eq("busy_after_capture", {31'b0, busy_o}, 32'd1);
      if (mid && edges == 5) ov_exp = 1'b1;
      done_i = keep | (mid && edges == 5);
    end while (!valid_o && edges < 40);

    check_eq("latency", edges, (nv == 0) ? 32'd1 : 32'd18);
    check_eq("mean", {16'b0, mean_o}, {16'b0, em16});
    check_eq("rem", {23'b0, rem_o}, {23'b0, er9});
    check_eq("div_zero", {31'b0, div_zero_o}, (nv == 0) ? 32'd1 : 32'd0);
    check_eq("busy_in_valid", {31'b0, busy_o}, 32'd0);
    check_eq("overrun", {31'b0, overrun_o}, {31'b0, ov_exp});

    repeat (hold) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check_eq("valid_held", {31'b0, valid_o}, 32'd1);
      check_eq("mean_stable", {16'b0, mean_o}, {16'b0, em16});
      check_eq("rem_stable", {23'b0, rem_o}, {23'b0, er9});
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("valid_after_xfer", {31'b0, valid_o}, 32'd0);
    ready_i = 1'b0;

    if (keep) begin
      repeat (8) begin
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("no_second_result", {31'b0, valid_o | busy_o}, 32'd0);
      end
      done_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] rs;
    logic [7:0]  rn;
    rst_ni  = 1'b0;
    done_i  = 1'b0;
    sum_i   = '0;
    n_i     = '0;
    ready_i = 1'b0;
    #12;
    check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst_busy", {31'b0, busy_o}, 32'd0);
    check_eq("rst_overrun", {31'b0, overrun_o}, 32'd0);
    check_eq("rst_mean", {16'b0, mean_o}, 32'd0);
    check_eq("rst_rem", {23'b0, rem_o}, 32'd0);
    check_eq("rst_dz", {31'b0, div_zero_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases
    run_batch(16'd100, 8'd7, 0, 1'b0, 1'b0);
    run_batch(-16'sd100, 8'd7, 0, 1'b0, 1'b0);
    run_batch(-16'sd5, 8'd10, 0, 1'b0, 1'b0);
    run_batch(16'h8000, 8'd1, 0, 1'b0, 1'b0);
    run_batch(16'h7fff, 8'd255, 0, 1'b0, 1'b0);
    run_batch(16'd1234, 8'd0, 0, 1'b1, 1'b0);
    run_batch(-16'sd3000, 8'd13, 5, 1'b0, 1'b0);
    run_batch(16'd999, 8'd4, 0, 1'b0, 1'b1);
    run_batch(16'd50, 8'd3, 1, 1'b0, 1'b0);

    // Reset in the middle of DIV with done_i still high
    @(negedge clk_i);
    done_i  = 1'b1;
    sum_i   = 16'd1234;
    n_i     = 8'd9;
    ready_i = 1'b0;
    @(posedge clk_i);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("busy_before_reset", {31'b0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    ov_exp = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check_eq("mid_rst_overrun", {31'b0, overrun_o}, 32'd0);
    check_eq("mid_rst_mean", {16'b0, mean_o}, 32'd0);
    check_eq("mid_rst_rem", {23'b0, rem_o}, 32'd0);
    check_eq("mid_rst_dz", {31'b0, div_zero_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check_eq("no_capture_after_rst", {31'b0, busy_o | valid_o}, 32'd0);
    end
    done_i = 1'b0;
    run_batch(-16'sd100, 8'd7, 2, 1'b0, 1'b0);

    // Randomized batches
    for (int i = 0; i < 30; i++) begin
      rs = 16'($urandom);
      rn = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_batch(rs, rn, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
